// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pc_fetch_unit_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/pc_fetch_unit_hold_buffer.sv
// One-entry PC/instruction buffer parking a returned fetch while IF/ID is stalled.
module fetch_hold_buffer
  import pc_fetch_unit_pkg::*;
(
  input  logic            gclk,
  input  logic            grst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= DEF_NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC, instruction-memory handshake, IF/ID register, redirect/flush.
// Optional MISALIGN_TRAP_EN adds MISALIGN_FAULT / FAULT_PC for unaligned redirect targets.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = DEF_NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] BRANCH_JUMP_PC,
  input  logic            BRANCH_JUMP_TAKEN,
  input  logic            STALL,
  input  logic [XLEN-1:0] IMEM_READDATA,
  input  logic            IMEM_BUSYWAIT,
  output logic            IMEM_READ,
  output logic [XLEN-1:0] IMEM_ADDR,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_PC4,
  output logic [XLEN-1:0] IFID_INSTR,
  output logic            IFID_VALID,
  output logic            FETCH_STALL
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            MISALIGN_FAULT,
  output logic [XLEN-1:0] FAULT_PC
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  ifid_t           ifid_q, ifid_d;
  logic            hb_load, hb_clear, hb_valid;
  logic [XLEN-1:0] hb_pc, hb_instr;
  logic [XLEN-1:0] tgt;

  assign tgt = align_pc(BRANCH_JUMP_PC);

  fetch_hold_buffer u_hold (
    .gclk     (CLK),
    .grst     (RESET),
    .load     (hb_load),
    .clear    (hb_clear),
    .pc_in    (pc_q),
    .instr_in (IMEM_READDATA),
    .valid    (hb_valid),
    .pc       (hb_pc),
    .instr    (hb_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    ifid_d      = ifid_q;
    hb_load     = 1'b0;
    hb_clear    = BRANCH_JUMP_TAKEN;
    IMEM_READ   = 1'b0;
    IMEM_ADDR   = pc_q;
    FETCH_STALL = 1'b0;

    // A redirect always flushes IF/ID; PC fields keep their last value under a bubble.
    if (BRANCH_JUMP_TAKEN) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end

    case (state_q)
      IDLE: begin
        FETCH_STALL = 1'b1;
        state_d     = FETCH;
        if (BRANCH_JUMP_TAKEN) pc_d = tgt;
      end

      FETCH: begin
        IMEM_READ   = 1'b1;
        FETCH_STALL = IMEM_BUSYWAIT;
        if (BRANCH_JUMP_TAKEN) begin
          if (IMEM_BUSYWAIT) begin
            pend_d  = tgt;
            state_d = DRAIN;
          end else begin
            pc_d = tgt;
          end
        end else if (IMEM_BUSYWAIT) begin
          if (!STALL) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
          end
        end else if (!STALL) begin
          ifid_d = '{pc: pc_q, pc4: pc_q + XLEN'(4), instr: IMEM_READDATA, valid: 1'b1};
          pc_d   = pc_q + XLEN'(4);
        end else begin
          hb_load = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (BRANCH_JUMP_TAKEN) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!STALL) begin
          ifid_d   = '{pc: hb_pc, pc4: hb_pc + XLEN'(4), instr: hb_instr, valid: hb_valid};
          hb_clear = 1'b1;
          pc_d     = pc_q + XLEN'(4);
          state_d  = FETCH;
        end
      end

      DRAIN: begin
        // The abandoned request stays on the bus until memory answers; its data is dropped.
        IMEM_READ   = 1'b1;
        FETCH_STALL = 1'b1;
        if (BRANCH_JUMP_TAKEN) pend_d = tgt;
        if (!IMEM_BUSYWAIT) begin
          pc_d    = BRANCH_JUMP_TAKEN ? tgt : pend_q;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      ifid_q  <= '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ifid_q  <= ifid_d;
    end
  end

  assign IFID_PC    = ifid_q.pc;
  assign IFID_PC4   = ifid_q.pc4;
  assign IFID_INSTR = ifid_q.instr;
  assign IFID_VALID = ifid_q.valid;

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MISALIGN_FAULT <= 1'b0;
      FAULT_PC       <= '0;
    end else begin
      MISALIGN_FAULT <= BRANCH_JUMP_TAKEN & (|BRANCH_JUMP_PC[1:0]);
      if (BRANCH_JUMP_TAKEN & (|BRANCH_JUMP_PC[1:0])) FAULT_PC <= BRANCH_JUMP_PC;
    end
  end
`endif

endmodule
